quote_order_scheduler: RTL and testbench

Sequences quote updates from the quoting datapath into discrete order messages for the order-entry path. Keeps one pending quote, newest wins, and compares it with the currently live buy and sell orders. Emits only the cancel/new pairs needed to move the book onto the new quote, over a valid/ready port. Enforces a minimum gap between update bursts and flattens all live orders when trading is disabled.

---
 rtl/quote_order_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_quote_order_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quote_order_scheduler.sv
// rtl/quote_order_scheduler.sv - quote-to-order burst sequencer with cooldown and flatten
module quote_order_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int QTY_WIDTH  = 16,
    parameter int ID_WIDTH   = 16,
    parameter int ORDER_QTY  = 100,
    parameter int MIN_GAP    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_buy_price,
    input  logic [DATA_WIDTH-1:0] i_ask_price,
    input  logic                  i_quote_valid,
    input  logic                  i_enable,
    output logic                  o_order_valid,
    input  logic                  i_order_ready,
    output logic [1:0]            o_order_type,
    output logic [DATA_WIDTH-1:0] o_order_price,
    output logic [QTY_WIDTH-1:0]  o_order_qty,
    output logic [ID_WIDTH-1:0]   o_order_id,
    output logic                  o_live_buy,
    output logic                  o_live_sell,
    output logic [DATA_WIDTH-1:0] o_live_buy_price,
    output logic [DATA_WIDTH-1:0] o_live_ask_price,
    output logic                  o_busy,
    output logic                  o_drop_pulse
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP);
    localparam logic [QTY_WIDTH-1:0] QTY_NEW  = QTY_WIDTH'(ORDER_QTY);
    localparam logic [ID_WIDTH-1:0]  ID_ONE   = ID_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CXL_BUY, S_NEW_BUY, S_CXL_SELL, S_NEW_SELL, S_FLAT_BUY, S_FLAT_SELL
    } state_t;

    state_t                state, state_n;
    logic                  pend_v;
    logic [DATA_WIDTH-1:0] pend_buy, pend_ask;
    logic [DATA_WIDTH-1:0] work_buy, work_ask, work_buy_n, work_ask_n;
    logic [GAP_W-1:0]      gap_cnt;
    logic [ID_WIDTH-1:0]   id_cnt, id_cnt_n, id_inc;
    logic [ID_WIDTH-1:0]   live_buy_id, live_sell_id, live_buy_id_n, live_sell_id_n;
    logic                  live_buy_n, live_sell_n;
    logic [DATA_WIDTH-1:0] live_buy_px_n, live_ask_px_n;
    logic                  quote_ok, xfer, take, in_burst, load_gap, sell_needs;
    logic [1:0]            type_n;
    logic [DATA_WIDTH-1:0] price_n;
    logic [QTY_WIDTH-1:0]  qty_n;
    logic [ID_WIDTH-1:0]   id_n;

    assign quote_ok = i_quote_valid && i_enable && (i_buy_price != '0) &&
                      (i_ask_price != '0) && (i_buy_price < i_ask_price);
    assign xfer     = o_order_valid && i_order_ready;
    assign in_burst = (state == S_CXL_BUY) || (state == S_NEW_BUY) ||
                      (state == S_CXL_SELL) || (state == S_NEW_SELL);
    // Id 0 is reserved, so the counter skips it on wrap.
    assign id_inc     = (id_cnt == '1) ? ID_ONE : id_cnt + ID_ONE;
    assign sell_needs = !o_live_sell || (work_ask != o_live_ask_price);

    always_comb begin
        state_n        = state;
        take           = 1'b0;
        load_gap       = 1'b0;
        work_buy_n     = work_buy;
        work_ask_n     = work_ask;
        live_buy_n     = o_live_buy;
        live_sell_n    = o_live_sell;
        live_buy_px_n  = o_live_buy_price;
        live_ask_px_n  = o_live_ask_price;
        live_buy_id_n  = live_buy_id;
        live_sell_id_n = live_sell_id;
        id_cnt_n       = id_cnt;
        type_n         = 2'd0;
        price_n        = '0;
        qty_n          = '0;
        id_n           = '0;

        if (state == S_IDLE) begin
            if (!i_enable && (o_live_buy || o_live_sell)) begin
                state_n = o_live_buy ? S_FLAT_BUY : S_FLAT_SELL;
            end else if (pend_v && i_enable && (gap_cnt == '0)) begin
                take       = 1'b1;
                work_buy_n = pend_buy;
                work_ask_n = pend_ask;
                if (!o_live_buy || (pend_buy != o_live_buy_price))
                    state_n = o_live_buy ? S_CXL_BUY : S_NEW_BUY;
                else if (!o_live_sell || (pend_ask != o_live_ask_price))
                    state_n = o_live_sell ? S_CXL_SELL : S_NEW_SELL;
            end
        end else if (xfer) begin
            case (state)
                S_CXL_BUY, S_FLAT_BUY: begin
                    live_buy_n    = 1'b0;
                    live_buy_px_n = '0;
                end
                S_NEW_BUY: begin
                    live_buy_n    = 1'b1;
                    live_buy_px_n = work_buy;
                    live_buy_id_n = id_cnt;
                    id_cnt_n      = id_inc;
                end
                S_CXL_SELL, S_FLAT_SELL: begin
                    live_sell_n   = 1'b0;
                    live_ask_px_n = '0;
                end
                S_NEW_SELL: begin
                    live_sell_n    = 1'b1;
                    live_ask_px_n  = work_ask;
                    live_sell_id_n = id_cnt;
                    id_cnt_n       = id_inc;
                end
                default: ;
            endcase
            case (state)
                S_CXL_BUY:  state_n = S_NEW_BUY;
                S_NEW_BUY:  state_n = sell_needs ? (o_live_sell ? S_CXL_SELL : S_NEW_SELL) : S_IDLE;
                S_CXL_SELL: state_n = S_NEW_SELL;
                S_FLAT_BUY: state_n = o_live_sell ? S_FLAT_SELL : S_IDLE;
                default:    state_n = S_IDLE;
            endcase
            // Disable lands here only once the in-flight message has gone out.
            if (!i_enable && in_burst)
                state_n = live_buy_n ? S_FLAT_BUY : (live_sell_n ? S_FLAT_SELL : S_IDLE);
            load_gap = in_burst && (state_n == S_IDLE);
        end

        case (state_n)
            S_NEW_BUY: begin
                type_n = 2'd0; price_n = work_buy_n; qty_n = QTY_NEW; id_n = id_cnt_n;
            end
            S_NEW_SELL: begin
                type_n = 2'd1; price_n = work_ask_n; qty_n = QTY_NEW; id_n = id_cnt_n;
            end
            S_CXL_BUY, S_FLAT_BUY: begin
                type_n = 2'd2; price_n = live_buy_px_n; id_n = live_buy_id_n;
            end
            S_CXL_SELL, S_FLAT_SELL: begin
                type_n = 2'd3; price_n = live_ask_px_n; id_n = live_sell_id_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            pend_v           <= 1'b0;
            pend_buy         <= '0;
            pend_ask         <= '0;
            work_buy         <= '0;
            work_ask         <= '0;
            gap_cnt          <= '0;
            id_cnt           <= ID_ONE;
            live_buy_id      <= '0;
            live_sell_id     <= '0;
            o_live_buy       <= 1'b0;
            o_live_sell      <= 1'b0;
            o_live_buy_price <= '0;
            o_live_ask_price <= '0;
            o_order_valid    <= 1'b0;
            o_busy           <= 1'b0;
            o_order_type     <= 2'd0;
            o_order_price    <= '0;
            o_order_qty      <= '0;
            o_order_id       <= '0;
            o_drop_pulse     <= 1'b0;
        end else begin
            state        <= state_n;
            o_drop_pulse <= i_quote_valid && i_enable && !quote_ok;

            // A same-cycle capture overrides the consume of the older quote.
            if (!i_enable) begin
                pend_v <= 1'b0;
            end else if (quote_ok) begin
                pend_v   <= 1'b1;
                pend_buy <= i_buy_price;
                pend_ask <= i_ask_price;
            end else if (take) begin
                pend_v <= 1'b0;
            end

            work_buy         <= work_buy_n;
            work_ask         <= work_ask_n;
            id_cnt           <= id_cnt_n;
            live_buy_id      <= live_buy_id_n;
            live_sell_id     <= live_sell_id_n;
            o_live_buy       <= live_buy_n;
            o_live_sell      <= live_sell_n;
            o_live_buy_price <= live_buy_px_n;
            o_live_ask_price <= live_ask_px_n;

            if (load_gap)
                gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);

            if (state_n != state) begin
                o_order_valid <= (state_n != S_IDLE);
                o_busy        <= (state_n != S_IDLE);
                o_order_type  <= type_n;
                o_order_price <= price_n;
                o_order_qty   <= qty_n;
                o_order_id    <= id_n;
            end
        end
    end

endmodule

// File: tb/tb_quote_order_scheduler.sv
// tb/tb_quote_order_scheduler.sv - scoreboard bench for quote_order_scheduler
module tb_quote_order_scheduler;

    localparam int DW = 32;
    localparam int QW = 16;
    localparam int IW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [DW-1:0] i_buy_price = '0;
    logic [DW-1:0] i_ask_price = '0;
    logic          i_quote_valid = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_order_ready = 1'b0;
    logic          o_order_valid;
    logic [1:0]    o_order_type;
    logic [DW-1:0] o_order_price;
    logic [QW-1:0] o_order_qty;
    logic [IW-1:0] o_order_id;
    logic          o_live_buy, o_live_sell;
    logic [DW-1:0] o_live_buy_price, o_live_ask_price;
    logic          o_busy, o_drop_pulse;

    quote_order_scheduler #(
        .DATA_WIDTH(DW), .QTY_WIDTH(QW), .ID_WIDTH(IW), .ORDER_QTY(100), .MIN_GAP(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_buy_price(i_buy_price), .i_ask_price(i_ask_price),
        .i_quote_valid(i_quote_valid), .i_enable(i_enable),
        .o_order_valid(o_order_valid), .i_order_ready(i_order_ready),
        .o_order_type(o_order_type), .o_order_price(o_order_price),
        .o_order_qty(o_order_qty), .o_order_id(o_order_id),
        .o_live_buy(o_live_buy), .o_live_sell(o_live_sell),
        .o_live_buy_price(o_live_buy_price), .o_live_ask_price(o_live_ask_price),
        .o_busy(o_busy), .o_drop_pulse(o_drop_pulse)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0]    t;
        logic [DW-1:0] p;
        logic [QW-1:0] q;
        logic [IW-1:0] id;
    } msg_t;

    msg_t exp_q[$];
    msg_t mon_act, mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   msg_n  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [DW-1:0] p,
                        input logic [QW-1:0] q, input logic [IW-1:0] id);
        msg_t m;
        m.t = t; m.p = p; m.q = q; m.id = id;
        exp_q.push_back(m);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_quote(input logic [DW-1:0] b, input logic [DW-1:0] a);
        i_buy_price   = b;
        i_ask_price   = a;
        i_quote_valid = 1'b1;
        tick();
        i_quote_valid = 1'b0;
    endtask

    task automatic wait_burst(input string name);
        int n = 0;
        while (!o_busy && n < 60) begin tick(); n++; end
        while (o_busy && n < 60) begin tick(); n++; end
        chk({name, "_timeout"}, 64'(o_busy), 64'd0);
    endtask

    // Scoreboard monitor: a transfer happens at the next rising edge.
    always @(negedge i_clk) begin
        if (i_rst_n && o_order_valid && i_order_ready) begin
            msg_n++;
            checks++;
            mon_act.t = o_order_type; mon_act.p = o_order_price;
            mon_act.q = o_order_qty;  mon_act.id = o_order_id;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL msg%0d unexpected t=%0d p=%0d q=%0d id=%0d",
                         msg_n, mon_act.t, mon_act.p, mon_act.q, mon_act.id);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL msg%0d actual t=%0d p=%0d q=%0d id=%0d expected t=%0d p=%0d q=%0d id=%0d",
                             msg_n, mon_act.t, mon_act.p, mon_act.q, mon_act.id,
                             mon_exp.t, mon_exp.p, mon_exp.q, mon_exp.id);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        i_enable = 1'b1;
        i_order_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 64'(o_order_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_live", 64'({o_live_buy, o_live_sell}), 64'd0);
        chk("rst_prices", 64'(o_live_buy_price | o_live_ask_price), 64'd0);
        chk("rst_payload", 64'(o_order_price | o_order_id | o_order_qty | o_order_type), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // First burst: both sides new, back to back, 2-cycle latency
        push(2'd0, 100, 100, 1);
        push(2'd1, 102, 100, 2);
        send_quote(100, 102);
        chk("lat_k", 64'(o_order_valid), 64'd0);
        tick();
        chk("lat_k1", 64'(o_order_valid), 64'd1);
        tick();
        chk("b2b_second", 64'(o_order_type), 64'd1);
        tick();
        chk("b2b_done", 64'(o_busy), 64'd0);
        chk("live1_buy", 64'(o_live_buy_price), 64'd100);
        chk("live1_ask", 64'(o_live_ask_price), 64'd102);

        // Sell-only update
        repeat (20) tick();
        push(2'd3, 102, 0, 2);
        push(2'd1, 103, 100, 3);
        send_quote(100, 103);
        wait_burst("burst2");
        chk("live2_buy", 64'(o_live_buy_price), 64'd100);
        chk("live2_ask", 64'(o_live_ask_price), 64'd103);

        // Quotes during cooldown: newest wins, first message at MIN_GAP+1
        push(2'd2, 100, 0, 1);
        push(2'd0, 107, 100, 4);
        push(2'd3, 103, 0, 3);
        push(2'd1, 109, 100, 5);
        send_quote(101, 104);
        send_quote(105, 106);
        send_quote(107, 109);
        n = 0;
        while (!o_order_valid && n < 40) begin tick(); n++; end
        chk("gap_wait", 64'(n), 64'd14);
        wait_burst("burst3");
        chk("live3_buy", 64'(o_live_buy_price), 64'd107);
        chk("live3_ask", 64'(o_live_ask_price), 64'd109);

        // Invalid quotes
        repeat (20) tick();
        send_quote(110, 110);
        chk("drop_crossed", 64'(o_drop_pulse), 64'd1);
        send_quote(0, 50);
        chk("drop_zero", 64'(o_drop_pulse), 64'd1);
        tick();
        chk("drop_clear", 64'(o_drop_pulse), 64'd0);
        repeat (5) tick();
        chk("drop_idle", 64'(o_busy), 64'd0);
        chk("drop_live_buy", 64'(o_live_buy_price), 64'd107);
        chk("drop_live_ask", 64'(o_live_ask_price), 64'd109);

        // Reset mid-burst with the cancel stalled
        i_order_ready = 1'b0;
        send_quote(111, 112);
        tick();
        chk("stall_type", 64'(o_order_type), 64'd2);
        chk("stall_price", 64'(o_order_price), 64'd107);
        chk("stall_id", 64'(o_order_id), 64'd4);
        tick();
        i_rst_n = 1'b0;
        tick();
        chk("mrst_valid", 64'(o_order_valid), 64'd0);
        chk("mrst_busy", 64'(o_busy), 64'd0);
        chk("mrst_live", 64'({o_live_buy, o_live_sell}), 64'd0);
        chk("mrst_payload", 64'(o_order_price | o_order_id), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // Disable while NEW_BUY is stalled, then flatten the buy
        send_quote(100, 102);
        tick();
        chk("hold_type", 64'(o_order_type), 64'd0);
        chk("hold_id_restart", 64'(o_order_id), 64'd1);
        i_enable = 1'b0;
        repeat (3) tick();
        chk("hold_valid", 64'(o_order_valid), 64'd1);
        chk("hold_payload", 64'({o_order_type, o_order_price, o_order_id}), 64'({2'd0, 32'd100, 16'd1}));
        push(2'd0, 100, 100, 1);
        push(2'd2, 100, 0, 1);
        i_order_ready = 1'b1;
        wait_burst("flat1");
        chk("flat1_live", 64'({o_live_buy, o_live_sell}), 64'd0);

        // Flatten both sides from IDLE during cooldown
        i_enable = 1'b1;
        repeat (2) tick();
        push(2'd0, 200, 100, 2);
        push(2'd1, 210, 100, 3);
        send_quote(200, 210);
        wait_burst("burst4");
        push(2'd2, 200, 0, 2);
        push(2'd3, 210, 0, 3);
        i_enable = 1'b0;
        tick();
        chk("flat_ignores_gap", 64'(o_order_valid), 64'd1);
        wait_burst("flat2");
        chk("flat2_live", 64'({o_live_buy, o_live_sell}), 64'd0);
        chk("flat2_prices", 64'(o_live_buy_price | o_live_ask_price), 64'd0);

        repeat (3) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
